// File: rtl/demux_lane_scheduler_if.sv
// Handshake and demux-side bus of the 1-to-4 demux lane scheduler.
// The slave modport is the scheduler itself, and the master modport is its upstream/observer.
interface demux_lane_scheduler_if #(
  parameter int unsigned CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_data;
  logic [3:0]       in_mask;
  logic             pause;
  logic             f;
  logic [1:0]       sel;
  logic             f_valid;
  logic             done;
  logic [CNT_W-1:0] frame_cnt;

  modport master (
    output in_valid, in_data, in_mask, pause,
    input  in_ready, f, sel, f_valid, done, frame_cnt
  );

  modport slave (
    input  in_valid, in_data, in_mask, pause,
    output in_ready, f, sel, f_valid, done, frame_cnt
  );
endinterface

// File: rtl/demux_lane_scheduler.sv
// Serialises a masked 4-bit word onto the demux input f, one lane at a time.
// A one-cycle guard follows each frame, and a wrapping counter records completed frames.
module demux_lane_scheduler #(
  parameter int unsigned HOLD  = 1,
  parameter int unsigned CNT_W = 8
) (
  input logic                   clk,
  input logic                   rst,
  demux_lane_scheduler_if.slave bus
);
  localparam int unsigned HOLD_W = $clog2(HOLD + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, DRIVE = 2'd1, GAP = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [3:0]         data_q, data_d;
  logic [3:0]         mask_q, mask_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [1:0]         sel_q, sel_d;
  logic               f_q, f_d;
  logic               f_valid_q, f_valid_d;
  logic               done_q, done_d;
  logic               ready_q, ready_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [1:0]         first_lane;
  logic [1:0]         next_lane;
  logic               has_next;

  // Lowest set bit of the incoming mask.
  always_comb begin
    first_lane = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (bus.in_mask[k]) first_lane = 2'(k);
    end
  end

  // Lowest latched-mask lane above the lane currently driven.
  always_comb begin
    next_lane = sel_q;
    has_next  = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (mask_q[k] && (k > int'(sel_q))) begin
        next_lane = 2'(k);
        has_next  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      data_q    <= 4'd0;
      mask_q    <= 4'd0;
      hold_q    <= '0;
      sel_q     <= 2'd0;
      f_q       <= 1'b0;
      f_valid_q <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      mask_q    <= mask_d;
      hold_q    <= hold_d;
      sel_q     <= sel_d;
      f_q       <= f_d;
      f_valid_q <= f_valid_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state logic; the output registers are loaded with the values for the next state.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    mask_d    = mask_q;
    hold_d    = hold_q;
    sel_d     = sel_q;
    f_d       = 1'b0;
    f_valid_d = 1'b0;
    done_d    = 1'b0;
    ready_d   = 1'b0;
    cnt_d     = cnt_q;

    unique case (state_q)
      IDLE: begin
        ready_d = ~bus.pause;
        if (bus.in_valid && ready_q) begin
          data_d = bus.in_data;
          mask_d = bus.in_mask;
          hold_d = '0;
          if (bus.in_mask != 4'd0) begin
            state_d   = DRIVE;
            sel_d     = first_lane;
            f_d       = bus.in_data[first_lane];
            f_valid_d = 1'b1;
            ready_d   = 1'b0;
          end else begin
            done_d = 1'b1;
            cnt_d  = cnt_q + CNT_W'(1);
          end
        end
      end

      DRIVE: begin
        f_valid_d = 1'b1;
        f_d       = data_q[sel_q];
        if (!bus.pause) begin
          if (hold_q == HOLD_W'(HOLD - 1)) begin
            hold_d = '0;
            if (has_next) begin
              sel_d = next_lane;
              f_d   = data_q[next_lane];
            end else begin
              state_d   = GAP;
              f_d       = 1'b0;
              f_valid_d = 1'b0;
              done_d    = 1'b1;
            end
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
      end

      GAP: begin
        state_d = IDLE;
        ready_d = ~bus.pause;
        cnt_d   = cnt_q + CNT_W'(1);
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = ready_q;
  assign bus.f         = f_q;
  assign bus.sel       = sel_q;
  assign bus.f_valid   = f_valid_q;
  assign bus.done      = done_q;
  assign bus.frame_cnt = cnt_q;
endmodule

// File: tb/tb_demux_lane_scheduler.sv
// Scoreboard bench for demux_lane_scheduler: one instance with HOLD=1 and one with HOLD=3.
module tb_demux_lane_scheduler;
  logic clk = 1'b0;
  logic rst1 = 1'b1;
  logic rst3 = 1'b1;
  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic       f;
    logic [1:0] sel;
  } exp_t;

  exp_t expq[$];

  demux_lane_scheduler_if #(.CNT_W(8)) if1 ();
  demux_lane_scheduler_if #(.CNT_W(8)) if3 ();

  demux_lane_scheduler #(.HOLD(1), .CNT_W(8)) u_dut1 (.clk(clk), .rst(rst1), .bus(if1));
  demux_lane_scheduler #(.HOLD(3), .CNT_W(8)) u_dut3 (.clk(clk), .rst(rst3), .bus(if3));

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic test_reset();
    if1.in_valid = 1'b1; if1.in_mask = 4'hF; if1.in_data = 4'hA; if1.pause = 1'b0;
    if3.in_valid = 1'b0; if3.in_mask = 4'h0; if3.in_data = 4'h0; if3.pause = 1'b0;
    rst1 = 1'b1; rst3 = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if (if1.f !== 1'b0) begin miscompares++; $display("FAIL reset_f got %0b want 0", if1.f); end
    vectors++; if (if1.sel !== 2'd0) begin miscompares++; $display("FAIL reset_sel got %0d want 0", if1.sel); end
    vectors++; if (if1.f_valid !== 1'b0) begin miscompares++; $display("FAIL reset_f_valid got %0b want 0", if1.f_valid); end
    vectors++; if (if1.done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %0b want 0", if1.done); end
    vectors++; if (if1.frame_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_frame_cnt got %0d want 0", if1.frame_cnt); end
    vectors++; if (if1.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %0b want 1", if1.in_ready); end
    vectors++; if (if3.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset3_in_ready got %0b want 1", if3.in_ready); end
    if1.in_valid = 1'b0;
    @(negedge clk);
    rst1 = 1'b0; rst3 = 1'b0;
    @(negedge clk);
    vectors++; if (if1.f_valid !== 1'b0) begin miscompares++; $display("FAIL reset_no_accept got f_valid=%0b want 0", if1.f_valid); end
    vectors++; if (if1.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_idle_ready got %0b want 1", if1.in_ready); end
  endtask

  task automatic test_full_frame();
    exp_t e;
    expq.push_back('{1'b0, 2'd0}); expq.push_back('{1'b1, 2'd1});
    expq.push_back('{1'b0, 2'd2}); expq.push_back('{1'b1, 2'd3});
    if1.in_data = 4'b1010; if1.in_mask = 4'b1111; if1.in_valid = 1'b1;
    @(negedge clk);
    if1.in_valid = 1'b0; if1.in_data = 4'b0101; if1.in_mask = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      e = expq.pop_front();
      vectors++; if (if1.f_valid !== 1'b1) begin miscompares++; $display("FAIL full_f_valid[%0d] got %0b want 1", i, if1.f_valid); end
      vectors++; if (if1.f !== e.f) begin miscompares++; $display("FAIL full_f[%0d] got %0b want %0b", i, if1.f, e.f); end
      vectors++; if (if1.sel !== e.sel) begin miscompares++; $display("FAIL full_sel[%0d] got %0d want %0d", i, if1.sel, e.sel); end
      if (i == 0) begin
        vectors++; if (if1.in_ready !== 1'b0) begin miscompares++; $display("FAIL full_busy_ready got %0b want 0", if1.in_ready); end
      end
    end
    @(negedge clk);
    vectors++; if (if1.f_valid !== 1'b0) begin miscompares++; $display("FAIL full_gap_f_valid got %0b want 0", if1.f_valid); end
    vectors++; if (if1.f !== 1'b0) begin miscompares++; $display("FAIL full_gap_f got %0b want 0", if1.f); end
    vectors++; if (if1.sel !== 2'd3) begin miscompares++; $display("FAIL full_gap_sel got %0d want 3", if1.sel); end
    vectors++; if (if1.done !== 1'b1) begin miscompares++; $display("FAIL full_gap_done got %0b want 1", if1.done); end
    @(negedge clk);
    vectors++; if (if1.in_ready !== 1'b1) begin miscompares++; $display("FAIL full_ready_back got %0b want 1", if1.in_ready); end
    vectors++; if (if1.frame_cnt !== 8'd1) begin miscompares++; $display("FAIL full_frame_cnt got %0d want 1", if1.frame_cnt); end
    vectors++; if (if1.done !== 1'b0) begin miscompares++; $display("FAIL full_done_pulse got %0b want 0", if1.done); end
  endtask

  task automatic test_sparse();
    exp_t e;
    int drv = 0;
    bit gap = 1'b0;
    expq.push_back('{1'b0, 2'd0}); expq.push_back('{1'b1, 2'd2});
    if1.in_data = 4'b0100; if1.in_mask = 4'b0101; if1.in_valid = 1'b1;
    for (int i = 0; i < 8 && !gap; i++) begin
      @(negedge clk);
      if (i == 0) begin if1.in_valid = 1'b0; if1.in_mask = 4'hF; if1.in_data = 4'hF; end
      if (if1.f_valid === 1'b1) begin
        drv++;
        vectors++;
        if (expq.size() == 0) begin
          miscompares++; $display("FAIL sparse_extra_lane got sel=%0d want none", if1.sel);
        end else begin
          e = expq.pop_front();
          if (if1.f !== e.f || if1.sel !== e.sel) begin
            miscompares++; $display("FAIL sparse_lane got f=%0b sel=%0d want f=%0b sel=%0d", if1.f, if1.sel, e.f, e.sel);
          end
        end
      end else if (if1.done === 1'b1) begin
        gap = 1'b1;
      end
    end
    vectors++; if (!gap) begin miscompares++; $display("FAIL sparse_gap_timeout got no done want done within 8 cycles"); end
    vectors++; if (drv != 2) begin miscompares++; $display("FAIL sparse_drive_cycles got %0d want 2", drv); end
    vectors++; if (if1.sel !== 2'd2) begin miscompares++; $display("FAIL sparse_gap_sel got %0d want 2", if1.sel); end
    @(negedge clk);
    vectors++; if (if1.frame_cnt !== 8'd2) begin miscompares++; $display("FAIL sparse_frame_cnt got %0d want 2", if1.frame_cnt); end
    expq.delete();
  endtask

  task automatic test_empty_mask();
    if1.in_data = 4'hF; if1.in_mask = 4'h0; if1.in_valid = 1'b1;
    @(negedge clk);
    if1.in_valid = 1'b0;
    vectors++; if (if1.done !== 1'b1) begin miscompares++; $display("FAIL empty_done got %0b want 1", if1.done); end
    vectors++; if (if1.f_valid !== 1'b0) begin miscompares++; $display("FAIL empty_f_valid got %0b want 0", if1.f_valid); end
    vectors++; if (if1.in_ready !== 1'b1) begin miscompares++; $display("FAIL empty_ready got %0b want 1", if1.in_ready); end
    @(negedge clk);
    vectors++; if (if1.done !== 1'b0) begin miscompares++; $display("FAIL empty_done_pulse got %0b want 0", if1.done); end
    vectors++; if (if1.frame_cnt !== 8'd3) begin miscompares++; $display("FAIL empty_frame_cnt got %0d want 3", if1.frame_cnt); end
    vectors++; if (if1.f_valid !== 1'b0) begin miscompares++; $display("FAIL empty_f_valid_after got %0b want 0", if1.f_valid); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [4:0] fv_exp;
    logic [4:0] done_exp;
    fv_exp = 5'b01001;
    done_exp = 5'b10010;
    expq.push_back('{1'b1, 2'd0}); expq.push_back('{1'b1, 2'd0});
    if1.in_data = 4'b0001; if1.in_mask = 4'b0001; if1.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 4) if1.in_valid = 1'b0;
      vectors++; if (if1.f_valid !== fv_exp[i]) begin miscompares++; $display("FAIL b2b_f_valid[%0d] got %0b want %0b", i, if1.f_valid, fv_exp[i]); end
      vectors++; if (if1.done !== done_exp[i]) begin miscompares++; $display("FAIL b2b_done[%0d] got %0b want %0b", i, if1.done, done_exp[i]); end
      if (if1.f_valid === 1'b1 && expq.size() > 0) begin
        e = expq.pop_front();
        vectors++; if (if1.f !== e.f || if1.sel !== e.sel) begin miscompares++; $display("FAIL b2b_lane[%0d] got f=%0b sel=%0d want f=%0b sel=%0d", i, if1.f, if1.sel, e.f, e.sel); end
      end
      if (i == 2) begin
        vectors++; if (if1.in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_idle_ready got %0b want 1", if1.in_ready); end
      end
    end
    vectors++; if (expq.size() != 0) begin miscompares++; $display("FAIL b2b_frames got %0d pending want 0", expq.size()); end
    @(negedge clk);
    vectors++; if (if1.f_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_idle_f_valid got %0b want 0", if1.f_valid); end
    vectors++; if (if1.frame_cnt !== 8'd5) begin miscompares++; $display("FAIL b2b_frame_cnt got %0d want 5", if1.frame_cnt); end
    expq.delete();
  endtask

  task automatic test_hold_pause();
    exp_t e;
    for (int k = 0; k < 3; k++) expq.push_back('{1'b0, 2'd0});
    for (int k = 0; k < 5; k++) expq.push_back('{1'b1, 2'd1});
    if3.in_data = 4'b0010; if3.in_mask = 4'b0011; if3.in_valid = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (i == 1) begin if3.in_valid = 1'b0; if3.in_data = 4'b1101; end
      if (i <= 8) begin
        e = expq.pop_front();
        vectors++; if (if3.f_valid !== 1'b1 || if3.f !== e.f || if3.sel !== e.sel) begin
          miscompares++; $display("FAIL hold_lane[T+%0d] got fv=%0b f=%0b sel=%0d want fv=1 f=%0b sel=%0d", i, if3.f_valid, if3.f, if3.sel, e.f, e.sel);
        end
      end else begin
        vectors++; if (if3.f_valid !== 1'b0 || if3.done !== 1'b1 || if3.sel !== 2'd1) begin
          miscompares++; $display("FAIL hold_gap got fv=%0b done=%0b sel=%0d want fv=0 done=1 sel=1", if3.f_valid, if3.done, if3.sel);
        end
      end
      if3.pause = (i == 5 || i == 6);
    end
    @(negedge clk);
    vectors++; if (if3.in_ready !== 1'b1) begin miscompares++; $display("FAIL hold_ready_back got %0b want 1", if3.in_ready); end
    vectors++; if (if3.frame_cnt !== 8'd1) begin miscompares++; $display("FAIL hold_frame_cnt got %0d want 1", if3.frame_cnt); end
    if3.pause = 1'b1;
    @(negedge clk);
    vectors++; if (if3.in_ready !== 1'b0) begin miscompares++; $display("FAIL idle_pause_ready got %0b want 0", if3.in_ready); end
    if3.in_valid = 1'b1; if3.in_mask = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++; if (if3.in_ready !== 1'b0 || if3.f_valid !== 1'b0) begin
        miscompares++; $display("FAIL idle_pause_block[%0d] got ready=%0b fv=%0b want ready=0 fv=0", i, if3.in_ready, if3.f_valid);
      end
    end
    if3.in_valid = 1'b0; if3.pause = 1'b0;
    @(negedge clk);
    vectors++; if (if3.in_ready !== 1'b1) begin miscompares++; $display("FAIL idle_unpause_ready got %0b want 1", if3.in_ready); end
    vectors++; if (if3.frame_cnt !== 8'd1) begin miscompares++; $display("FAIL idle_pause_frame_cnt got %0d want 1", if3.frame_cnt); end
    expq.delete();
  endtask

  task automatic test_reset_mid_frame();
    bit found = 1'b0;
    if1.in_data = 4'hF; if1.in_mask = 4'hF; if1.in_valid = 1'b1;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if1.in_valid = 1'b0;
      if (if1.f_valid === 1'b1 && if1.sel === 2'd2) found = 1'b1;
    end
    vectors++; if (!found) begin miscompares++; $display("FAIL midrst_wait got no sel=2 want sel=2 within 10 cycles"); end
    rst1 = 1'b1;
    @(negedge clk);
    rst1 = 1'b0;
    vectors++; if (if1.f_valid !== 1'b0 || if1.f !== 1'b0) begin miscompares++; $display("FAIL midrst_f got fv=%0b f=%0b want 0 0", if1.f_valid, if1.f); end
    vectors++; if (if1.sel !== 2'd0) begin miscompares++; $display("FAIL midrst_sel got %0d want 0", if1.sel); end
    vectors++; if (if1.done !== 1'b0) begin miscompares++; $display("FAIL midrst_done got %0b want 0", if1.done); end
    vectors++; if (if1.frame_cnt !== 8'd0) begin miscompares++; $display("FAIL midrst_frame_cnt got %0d want 0", if1.frame_cnt); end
    vectors++; if (if1.in_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_ready got %0b want 1", if1.in_ready); end
    @(negedge clk);
    vectors++; if (if1.f_valid !== 1'b0 || if1.done !== 1'b0) begin miscompares++; $display("FAIL midrst_discard got fv=%0b done=%0b want 0 0", if1.f_valid, if1.done); end
  endtask

  task automatic test_wrap();
    if1.in_data = 4'h0; if1.in_mask = 4'h0; if1.in_valid = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      @(negedge clk);
      if (i == 255) begin
        vectors++; if (if1.frame_cnt !== 8'd255) begin miscompares++; $display("FAIL wrap_255 got %0d want 255", if1.frame_cnt); end
      end
      if (i == 256) begin
        if1.in_valid = 1'b0;
        vectors++; if (if1.frame_cnt !== 8'd0) begin miscompares++; $display("FAIL wrap_zero got %0d want 0", if1.frame_cnt); end
        vectors++; if (if1.done !== 1'b1) begin miscompares++; $display("FAIL wrap_done got %0b want 1", if1.done); end
      end
    end
    @(negedge clk);
    vectors++; if (if1.done !== 1'b0 || if1.frame_cnt !== 8'd0) begin miscompares++; $display("FAIL wrap_idle got done=%0b cnt=%0d want 0 0", if1.done, if1.frame_cnt); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_sparse();
    test_empty_mask();
    test_back_to_back();
    test_hold_pause();
    test_reset_mid_frame();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
